// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO pointer width and Gray/binary pointer conversions.
package fifo_pkg;
  localparam int PTR_W = 13;
  function automatic logic [PTR_W-1:0] bin2gray(input logic [PTR_W-1:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
    logic [PTR_W-1:0] b;
    b[PTR_W-1] = g[PTR_W-1];
    for (int i = PTR_W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/sync_r2w.sv
// sync_r2w: two-flop synchronizer bringing the Gray read pointer into wclk.
module sync_r2w #(
  parameter int WIDTH = 4
) (
  input  logic             wclk,
  input  logic             wrst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] q1;
  always_ff @(posedge wclk or posedge wrst)
    if (wrst) {q, q1} <= '0;
    else {q, q1} <= {q1, d};
endmodule

// File: rtl/wptr_full_ctrl.sv
// wptr_full_ctrl: async-FIFO write pointer, full/level/overflow flags.
// Define WPTR_ALMOST_FULL_EN to add the registered wafull output.
module wptr_full_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE     = 3,
  parameter int AFULL_THRESH = 6
) (
  input  logic                wclk,
  input  logic                wrst,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   rptr,
  output logic                wen,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                wovf
`ifdef WPTR_ALMOST_FULL_EN
  ,
  output logic                wafull
`endif
);
  localparam int A = ADDRSIZE;
  logic [A:0] wbin, wbinnext, wgraynext, rq2_rptr, rbin_s, lvlnext;
  sync_r2w #(.WIDTH(A + 1)) u_sync (.wclk(wclk), .wrst(wrst), .d(rptr), .q(rq2_rptr));
  assign wen       = winc & ~wfull & ~wrst;
  assign waddr     = wbin[A-1:0];
  assign wbinnext  = wbin + (A+1)'(wen);
  assign wgraynext = (A+1)'(bin2gray(PTR_W'(wbinnext)));
  assign rbin_s    = (A+1)'(gray2bin(PTR_W'(rq2_rptr)));
  assign lvlnext   = wbinnext - rbin_s;
  // Full when the next Gray pointer equals the read pointer with its top two bits inverted.
  always_ff @(posedge wclk or posedge wrst)
    if (wrst) begin
      wbin   <= '0;
      wptr   <= '0;
      wfull  <= 1'b0;
      wlevel <= '0;
      wovf   <= 1'b0;
    end else begin
      wbin   <= wbinnext;
      wptr   <= wgraynext;
      wfull  <= wgraynext == {~rq2_rptr[A:A-1], rq2_rptr[A-2:0]};
      wlevel <= lvlnext;
      wovf   <= winc & wfull;
    end
`ifdef WPTR_ALMOST_FULL_EN
  always_ff @(posedge wclk or posedge wrst)
    if (wrst) wafull <= 1'b0;
    else wafull <= lvlnext >= (A+1)'(AFULL_THRESH);
`endif
endmodule

// File: tb/tb_wptr_full_ctrl.sv
// tb_wptr_full_ctrl: directed vector bench for wptr_full_ctrl (ADDRSIZE=3, AFULL_THRESH=6).
module tb_wptr_full_ctrl;
  logic       wclk = 1'b0, wrst, winc;
  logic [3:0] rptr, wptr, wlevel;
  logic [2:0] waddr;
  logic       wen, wfull, wovf;
`ifdef WPTR_ALMOST_FULL_EN
  logic       wafull;
`endif
  int n_chk = 0, n_fail = 0;

  wptr_full_ctrl #(.ADDRSIZE(3), .AFULL_THRESH(6)) dut (
    .wclk(wclk), .wrst(wrst), .winc(winc), .rptr(rptr), .wen(wen), .waddr(waddr),
    .wptr(wptr), .wfull(wfull), .wlevel(wlevel), .wovf(wovf)
`ifdef WPTR_ALMOST_FULL_EN
    , .wafull(wafull)
`endif
  );

  always #5 wclk = ~wclk;

  typedef struct packed {
    logic       winc;
    logic [3:0] rptr;
    logic       wen;
    logic [3:0] wptr;
    logic       full;
    logic [3:0] lvl;
    logic       ovf;
    logic [2:0] addr;
  } vec_t;
  vec_t v[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] g(input int x);
    logic [3:0] b;
    b = 4'(x);
    return b ^ (b >> 1);
  endfunction

  initial begin
    v[0]  = '{1'b1, 4'b0000, 1'b1, 4'b0001, 1'b0, 4'd1, 1'b0, 3'd1};
    v[1]  = '{1'b1, 4'b0000, 1'b1, 4'b0011, 1'b0, 4'd2, 1'b0, 3'd2};
    v[2]  = '{1'b1, 4'b0000, 1'b1, 4'b0010, 1'b0, 4'd3, 1'b0, 3'd3};
    v[3]  = '{1'b1, 4'b0000, 1'b1, 4'b0110, 1'b0, 4'd4, 1'b0, 3'd4};
    v[4]  = '{1'b1, 4'b0000, 1'b1, 4'b0111, 1'b0, 4'd5, 1'b0, 3'd5};
    v[5]  = '{1'b1, 4'b0000, 1'b1, 4'b0101, 1'b0, 4'd6, 1'b0, 3'd6};
    v[6]  = '{1'b1, 4'b0000, 1'b1, 4'b0100, 1'b0, 4'd7, 1'b0, 3'd7};
    v[7]  = '{1'b1, 4'b0000, 1'b1, 4'b1100, 1'b1, 4'd8, 1'b0, 3'd0};
    v[8]  = '{1'b1, 4'b0000, 1'b0, 4'b1100, 1'b1, 4'd8, 1'b1, 3'd0};
    v[9]  = '{1'b1, 4'b0000, 1'b0, 4'b1100, 1'b1, 4'd8, 1'b1, 3'd0};
    v[10] = '{1'b0, 4'b0001, 1'b0, 4'b1100, 1'b1, 4'd8, 1'b0, 3'd0};
    v[11] = '{1'b0, 4'b0001, 1'b0, 4'b1100, 1'b1, 4'd8, 1'b0, 3'd0};
    v[12] = '{1'b0, 4'b0001, 1'b0, 4'b1100, 1'b0, 4'd7, 1'b0, 3'd0};
    v[13] = '{1'b1, 4'b0001, 1'b1, 4'b1101, 1'b1, 4'd8, 1'b0, 3'd1};
    v[14] = '{1'b0, 4'b0001, 1'b0, 4'b1101, 1'b1, 4'd8, 1'b0, 3'd1};
    wrst = 1'b1; winc = 1'b0; rptr = '0;
    #1;
    chk("reset_wptr", wptr, 0);
    chk("reset_wfull", wfull, 0);
    chk("reset_wlevel", wlevel, 0);
    chk("reset_wen", wen, 0);
    @(negedge wclk) wrst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge wclk);
      winc = v[i].winc;
      rptr = v[i].rptr;
      #1;
      chk($sformatf("v%0d_wen", i), wen, v[i].wen);
      @(posedge wclk);
      #1;
      chk($sformatf("v%0d_wptr", i), wptr, v[i].wptr);
      chk($sformatf("v%0d_wfull", i), wfull, v[i].full);
      chk($sformatf("v%0d_wlevel", i), wlevel, v[i].lvl);
      chk($sformatf("v%0d_wovf", i), wovf, v[i].ovf);
      chk($sformatf("v%0d_waddr", i), waddr, v[i].addr);
    end
    // reset mid-write while full and overflowing
    @(negedge wclk) winc = 1'b1;
    @(posedge wclk);
    #1;
    chk("pre_rst_wovf", wovf, 1);
    #2 wrst = 1'b1;
    #1;
    chk("rst_wen", wen, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wptr", wptr, 0);
    chk("rst_wfull", wfull, 0);
    chk("rst_wlevel", wlevel, 0);
    chk("rst_wovf", wovf, 0);
    @(negedge wclk);
    wrst = 1'b0; winc = 1'b0; rptr = '0;
    // 16 writes with the read pointer trailing by two
    for (int k = 1; k <= 16; k++) begin
      @(negedge wclk);
      winc = 1'b1;
      rptr = g(k > 2 ? k - 2 : 0);
      @(posedge wclk);
      #1;
      chk($sformatf("wrap%0d_wfull", k), wfull, 0);
      if (k == 1) chk("wrap1_wlevel", wlevel, 1);
    end
    @(negedge wclk) winc = 1'b0;
    chk("wrap_wptr", wptr, 4'b0000);
    chk("wrap_waddr", waddr, 0);
`ifdef WPTR_ALMOST_FULL_EN
    wrst = 1'b1;
    @(negedge wclk);
    wrst = 1'b0; rptr = '0; winc = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge wclk);
      #1;
      if (k == 5) chk("afull_5", wafull, 0);
      if (k == 6) chk("afull_6", wafull, 1);
    end
    winc = 1'b0;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
